roulette_wheel_spinner: RTL and testbench

Producer side of the roulette game's random-number interface. It supplies the 5-bit result (`randnum`) that the even/odd guessing game consumes, and it animates a "ball" position that the HEX/LED display can show while the wheel spins. A spin is started by a request and slows down over time. The final result is held with a valid flag until the game acknowledges it. Randomness comes from a free-running 16-bit LFSR.

---
 rtl/roulette_wheel_spinner.sv | 135 +++++++++++++
 tb/tb_roulette_wheel_spinner.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/roulette_wheel_spinner.sv
// Roulette spinner: free-running LFSR picks extra steps, animated ball decelerates, result held until acked.
// Latency: STEP_BASE*(SPIN_STEPS+extra) + STEP_BASE*sum(k+1, k=1..SLOW_STEPS) cycles from accept to result_valid.
// Backpressure: result held in PRESENT until result_ack; spin_req outside IDLE is dropped. Option: ROULETTE_GREEN_ZERO_EN.
module roulette_wheel_spinner #(
    parameter int          SPIN_STEPS = 32,
    parameter int          SLOW_STEPS = 8,
    parameter int          STEP_BASE  = 4,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spin_req,
    input  logic       result_ack,
    output logic       spin_busy,
    output logic       result_valid,
    output logic [4:0] randnum,
    output logic       parity,
    output logic [4:0] ball_pos,
    output logic       result_green
);

    localparam int LEN_MAX   = STEP_BASE * (SLOW_STEPS + 1);
    localparam int LEN_W     = $clog2(LEN_MAX + 1);
    localparam int STEPS_MAX = (SPIN_STEPS + 31 > SLOW_STEPS) ? SPIN_STEPS + 31 : SLOW_STEPS;
    localparam int STEPS_W   = $clog2(STEPS_MAX + 1);

    localparam logic [LEN_W-1:0]   BASE_LEN  = LEN_W'(STEP_BASE);
    localparam logic [LEN_W-1:0]   BASE_LEN2 = LEN_W'(2 * STEP_BASE);
    localparam logic [STEPS_W-1:0] SPIN_N    = STEPS_W'(SPIN_STEPS);
    localparam logic [STEPS_W-1:0] SLOW_N    = STEPS_W'(SLOW_STEPS);
    localparam logic [15:0]        SEED      = (LFSR_SEED == 16'd0) ? 16'hACE1 : LFSR_SEED;
    localparam logic [15:0]        TAPS      = 16'hB400;

    typedef enum logic [1:0] {IDLE, SPIN, SLOW, PRESENT} state_t;

    state_t               state, state_nxt;
    logic [15:0]          lfsr, lfsr_nxt;
    logic [LEN_W-1:0]     cyc_cnt, step_len;
    logic [STEPS_W-1:0]   steps_left;
    logic [4:0]           ball_nxt;
    logic                 step_end, last_step, final_parity;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right
    assign lfsr_nxt  = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
    assign ball_nxt  = ball_pos + 5'd1;
    assign step_end  = (cyc_cnt == step_len - LEN_W'(1));
    assign last_step = (steps_left == STEPS_W'(1));

`ifdef ROULETTE_GREEN_ZERO_EN
    assign final_parity = (ball_nxt == 5'd0) ? 1'b0 : ~ball_nxt[0];
`else
    assign final_parity = ~ball_nxt[0];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (spin_req)              state_nxt = SPIN;
            SPIN:    if (step_end && last_step) state_nxt = SLOW;
            SLOW:    if (step_end && last_step) state_nxt = PRESENT;
            PRESENT: if (result_ack)            state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    always_comb begin
        spin_busy    = 1'b0;
        result_valid = 1'b0;
        result_green = 1'b0;
        case (state)
            SPIN, SLOW: spin_busy = 1'b1;
            PRESENT: begin
                result_valid = 1'b1;
`ifdef ROULETTE_GREEN_ZERO_EN
                result_green = (randnum == 5'd0);
`endif
            end
            default: ;
        endcase
    end

    // step_len grows by STEP_BASE per slow step, so no multiplier is needed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr       <= SEED;
            ball_pos   <= 5'd0;
            randnum    <= 5'd0;
            parity     <= 1'b1;
            cyc_cnt    <= '0;
            step_len   <= BASE_LEN;
            steps_left <= '0;
        end else begin
            lfsr <= lfsr_nxt;
            case (state)
                IDLE: begin
                    if (spin_req) begin
                        cyc_cnt    <= '0;
                        step_len   <= BASE_LEN;
                        steps_left <= SPIN_N + STEPS_W'(lfsr[4:0]);
                    end
                end
                SPIN, SLOW: begin
                    if (step_end) begin
                        cyc_cnt  <= '0;
                        ball_pos <= ball_nxt;
                        if (!last_step) begin
                            steps_left <= steps_left - STEPS_W'(1);
                            if (state == SLOW) begin
                                step_len <= step_len + BASE_LEN;
                            end
                        end else if (state == SPIN) begin
                            steps_left <= SLOW_N;
                            step_len   <= BASE_LEN2;
                        end else begin
                            randnum <= ball_nxt;
                            parity  <= final_parity;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_roulette_wheel_spinner.sv
// Bench for roulette_wheel_spinner: step-duration model checked every cycle plus literal scenario checks.
module tb_roulette_wheel_spinner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       spin_req = 1'b0;
    logic       result_ack = 1'b0;
    logic       spin_busy, result_valid, parity, result_green;
    logic [4:0] randnum, ball_pos;

    roulette_wheel_spinner dut (
        .clk          (clk),
        .reset        (reset),
        .spin_req     (spin_req),
        .result_ack   (result_ack),
        .spin_busy    (spin_busy),
        .result_valid (result_valid),
        .randnum      (randnum),
        .parity       (parity),
        .ball_pos     (ball_pos),
        .result_green (result_green)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Model: a spin is a list of step durations; the ball advances when each one runs out
    logic [15:0] m_lfsr, m_old;
    logic [4:0]  m_ball, m_rand;
    logic        m_par, m_valid, m_busy;
    int          m_left, m_extra, acc_cyc;
    int          durq[$];
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_lfsr = 16'hACE1; m_ball = 0; m_rand = 0; m_par = 1;
            m_valid = 0; m_busy = 0; m_left = 0; durq.delete();
        end else begin
            m_old  = m_lfsr;
            m_lfsr = lfsr_next(m_lfsr);
            if (!m_busy && !m_valid) begin
                if (spin_req) begin
                    m_extra = int'(m_old[4:0]);
                    durq.delete();
                    for (int i = 0; i < 32 + m_extra; i++) durq.push_back(4);
                    for (int k = 1; k <= 8; k++) durq.push_back(4 * (k + 1));
                    m_left  = durq.pop_front();
                    m_busy  = 1;
                    acc_cyc = cyc + 1;
                end
            end else if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_ball = m_ball + 5'd1;
                    if (durq.size() == 0) begin
                        m_busy  = 0;
                        m_valid = 1;
                        m_rand  = m_ball;
                        m_par   = ~m_ball[0];
`ifdef ROULETTE_GREEN_ZERO_EN
                        if (m_ball == 5'd0) m_par = 0;
`endif
                    end else begin
                        m_left = durq.pop_front();
                    end
                end
            end else if (result_ack) begin
                m_valid = 0;
            end
        end
    end

    logic [4:0] pball = 0, exp_b;
    logic       pvalid = 0, pm_busy = 0, trk = 0, wrap_seen = 0, exp_green;
    int         ivq[$];
    int         last_chg = 0, last_lat = 0, base_n;

    always @(negedge clk) begin
`ifdef ROULETTE_GREEN_ZERO_EN
        exp_green = m_valid && (m_rand == 5'd0);
`else
        exp_green = 1'b0;
`endif
        chk("spin_busy", spin_busy, m_busy);
        chk("result_valid", result_valid, m_valid);
        chk("randnum", randnum, m_rand);
        chk("parity", parity, m_par);
        chk("ball_pos", ball_pos, m_ball);
        chk("result_green", result_green, exp_green);
        if (reset) begin
            trk = 0;
        end else begin
            if (m_busy && !pm_busy) begin
                trk = 1; ivq.delete(); last_chg = acc_cyc;
            end
            if (trk && ball_pos != pball) begin
                exp_b = pball + 5'd1;
                chk("ball_increment", ball_pos, exp_b);
                if (pball == 5'd31) wrap_seen = 1;
                ivq.push_back(cyc - last_chg);
                last_chg = cyc;
            end
            if (trk && result_valid && !pvalid) begin
                last_lat = cyc - acc_cyc;
                chk("latency", last_lat, 4 * (32 + m_extra) + 176);
                chk("step_count", ivq.size(), 40 + m_extra);
                base_n = ivq.size() - 8;
                for (int i = 0; i < ivq.size(); i++)
                    chk("step_len", ivq[i], (i < base_n) ? 4 : 4 * (i - base_n + 2));
                trk = 0;
            end
        end
        pball = ball_pos; pvalid = result_valid; pm_busy = m_busy;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!result_valid && n < 2000) begin
            step();
            n++;
        end
        chk("valid_timeout", result_valid, 1);
        @(negedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, spin_busy, 0);
        chk({tag, "_valid"}, result_valid, 0);
        chk({tag, "_randnum"}, randnum, 0);
        chk({tag, "_parity"}, parity, 1);
        chk({tag, "_ball"}, ball_pos, 0);
        chk({tag, "_green"}, result_green, 0);
    endtask

    logic [4:0] need;
    bit         found;

    initial begin
        // 1: reset, spin on the first edge, extra = 1 -> 308 cycles, result 9
        step(); step();
        chk_reset_vals("reset");
        reset = 0; spin_req = 1;
        step();
        spin_req = 0;
        chk("accept_busy", spin_busy, 1);
        wait_valid();
        chk("s1_latency", last_lat, 308);
        chk("s1_randnum", randnum, 9);
        chk("s1_parity", parity, 0);
        chk("s1_wrap_seen", wrap_seen, 1);

        // 2: hold PRESENT with spin_req toggling, then ack
        for (int i = 0; i < 50; i++) begin
            spin_req = i[0];
            step();
        end
        spin_req = 0;
        chk("hold_valid", result_valid, 1);
        chk("hold_randnum", randnum, 9);
        chk("hold_ball", ball_pos, 9);
        result_ack = 1;
        step();
        result_ack = 0;
        chk("ack_valid", result_valid, 0);
        chk("ack_busy", spin_busy, 0);

        // 4: reset 100 cycles into a spin, then the first spin repeats exactly
        spin_req = 1;
        step();
        spin_req = 0;
        repeat (99) step();
        chk("midspin_busy", spin_busy, 1);
        reset = 1;
        #1;
        chk_reset_vals("async_reset");
        @(posedge clk);
        #2;
        reset = 0; spin_req = 1;
        step();
        spin_req = 0;
        wait_valid();
        chk("s4_latency", last_lat, 308);
        chk("s4_randnum", randnum, 9);
        chk("s4_parity", parity, 0);

        // 5: spin_req and ack together -> only ack; held spin_req accepted next edge
        spin_req = 1; result_ack = 1;
        step();
        result_ack = 0;
        chk("both_valid", result_valid, 0);
        chk("both_busy", spin_busy, 0);
        step();
        spin_req = 0;
        chk("next_busy", spin_busy, 1);
        wait_valid();
        result_ack = 1;
        step();
        result_ack = 0;

        // 6: pick the edge where extra lands the ball on pocket 0
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            need = 5'd24 - m_ball;
            if (m_lfsr[4:0] == need) found = 1;
            else step();
        end
        chk("green_search", found, 1);
        spin_req = 1;
        step();
        spin_req = 0;
        wait_valid();
        chk("zero_randnum", randnum, 0);
`ifdef ROULETTE_GREEN_ZERO_EN
        chk("zero_green", result_green, 1);
        chk("zero_parity", parity, 0);
`else
        chk("zero_green", result_green, 0);
        chk("zero_parity", parity, 1);
`endif
        result_ack = 1;
        step();
        result_ack = 0;
        chk("zero_green_clear", result_green, 0);
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
